// File: rtl/mbist_march_seq.sv
`default_nettype none
// ============================================================================
// Module   : mbist_march_seq
// Function : March C- sequencer steering the MBIST address generator, issuing
//            SRAM read/write ops and checking read data against background.
// Revision : 1.0 - initial release
// ============================================================================
module mbist_march_seq #(
    parameter int                      BIST_ADDR_WD  = 9,
    parameter int                      BIST_DATA_WD  = 32,
    parameter logic [BIST_DATA_WD-1:0] BIST_DATA_PAT = 32'h5555_5555,
    parameter int                      FAIL_CNT_WD   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bist_start,
    input  logic                    last_addr,
    input  logic [BIST_ADDR_WD-1:0] bist_addr,
    input  logic [BIST_DATA_WD-1:0] mem_rdata,
    output logic                    run,
    output logic                    updown,
    output logic                    scan_load,
    output logic                    mem_cs,
    output logic                    mem_we,
    output logic [BIST_DATA_WD-1:0] mem_wdata,
    output logic                    bist_busy,
    output logic                    bist_done,
    output logic                    bist_fail,
    output logic [BIST_ADDR_WD-1:0] fail_addr,
    output logic [FAIL_CNT_WD-1:0]  fail_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_TURN  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [2:0]             c_LAST_ELEM = 3'd5;
    localparam logic [2:0]             c_FIRST_DN  = 3'd3;
    localparam logic [FAIL_CNT_WD-1:0] c_CNT_MAX   = '1;

    state_t                  r_state_q,     w_state_d;
    logic [2:0]              r_elem_q,      w_elem_d;
    logic                    r_op_q,        w_op_d;
    logic                    r_cmp_vld_q,   w_cmp_vld_d;
    logic [BIST_DATA_WD-1:0] r_cmp_exp_q,   w_cmp_exp_d;
    logic [BIST_ADDR_WD-1:0] r_cmp_addr_q,  w_cmp_addr_d;
    logic                    r_fail_q,      w_fail_d;
    logic [BIST_ADDR_WD-1:0] r_fail_addr_q, w_fail_addr_d;
    logic [FAIL_CNT_WD-1:0]  r_fail_cnt_q,  w_fail_cnt_d;

    logic                    w_up;
    logic                    w_two_ops;
    logic                    w_last_op;
    logic                    w_is_wr;
    logic                    w_bkg;
    logic [BIST_DATA_WD-1:0] w_bkg_data;
    logic [2:0]              w_elem_inc;
    logic                    w_next_up;

    always_comb begin
        w_up       = (r_elem_q < c_FIRST_DN);
        w_two_ops  = (r_elem_q != 3'd0) && (r_elem_q != c_LAST_ELEM);
        w_last_op  = !w_two_ops || r_op_q;
        w_is_wr    = (r_elem_q == 3'd0) || r_op_q;
        // Writes in E0..E4 store background elem[0]; reads in E1..E5 expect its inverse
        w_bkg      = w_is_wr ? r_elem_q[0] : ~r_elem_q[0];
        w_bkg_data = w_bkg ? ~BIST_DATA_PAT : BIST_DATA_PAT;
        w_elem_inc = r_elem_q + 3'd1;
        w_next_up  = (w_elem_inc < c_FIRST_DN);
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_elem_d      = r_elem_q;
        w_op_d        = r_op_q;
        w_cmp_vld_d   = 1'b0;
        w_cmp_exp_d   = r_cmp_exp_q;
        w_cmp_addr_d  = r_cmp_addr_q;
        w_fail_d      = r_fail_q;
        w_fail_addr_d = r_fail_addr_q;
        w_fail_cnt_d  = r_fail_cnt_q;
        run           = 1'b0;
        updown        = 1'b1;
        scan_load     = 1'b0;
        mem_cs        = 1'b0;
        mem_we        = 1'b0;
        mem_wdata     = '0;
        bist_busy     = 1'b0;
        bist_done     = 1'b0;

        if (r_cmp_vld_q && (mem_rdata != r_cmp_exp_q)) begin
            w_fail_d = 1'b1;
            if (r_fail_cnt_q != c_CNT_MAX) begin
                w_fail_cnt_d = r_fail_cnt_q + FAIL_CNT_WD'(1);
            end
            if (!r_fail_q) begin
                w_fail_addr_d = r_cmp_addr_q;
            end
        end

        case (r_state_q)
            S_IDLE, S_DONE: begin
                bist_done = (r_state_q == S_DONE);
                if (bist_start) begin
                    w_fail_d      = 1'b0;
                    w_fail_addr_d = '0;
                    w_fail_cnt_d  = '0;
                    w_state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                bist_busy = 1'b1;
                scan_load = 1'b1;
                w_elem_d  = 3'd0;
                w_op_d    = 1'b0;
                w_state_d = S_RUN;
            end
            S_RUN: begin
                bist_busy = 1'b1;
                mem_cs    = 1'b1;
                mem_we    = w_is_wr;
                mem_wdata = w_bkg_data;
                updown    = w_up;
                if (!w_is_wr) begin
                    w_cmp_vld_d  = 1'b1;
                    w_cmp_exp_d  = w_bkg_data;
                    w_cmp_addr_d = bist_addr;
                end
                if (w_last_op) begin
                    run    = 1'b1;
                    w_op_d = 1'b0;
                    if (last_addr) begin
                        if (r_elem_q == c_LAST_ELEM) begin
                            w_state_d = S_DRAIN;
                        end else begin
                            w_elem_d = w_elem_inc;
                            if (w_next_up != w_up) begin
                                w_state_d = S_TURN;
                            end
                        end
                    end
                end else begin
                    w_op_d = 1'b1;
                end
            end
            S_TURN: begin
                // Generator wraps start->end so the down pass begins at the top
                bist_busy = 1'b1;
                run       = 1'b1;
                updown    = w_up;
                w_state_d = S_RUN;
            end
            S_DRAIN: begin
                bist_busy = 1'b1;
                w_state_d = S_DONE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_elem_q      <= 3'd0;
            r_op_q        <= 1'b0;
            r_cmp_vld_q   <= 1'b0;
            r_cmp_exp_q   <= '0;
            r_cmp_addr_q  <= '0;
            r_fail_q      <= 1'b0;
            r_fail_addr_q <= '0;
            r_fail_cnt_q  <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_elem_q      <= w_elem_d;
            r_op_q        <= w_op_d;
            r_cmp_vld_q   <= w_cmp_vld_d;
            r_cmp_exp_q   <= w_cmp_exp_d;
            r_cmp_addr_q  <= w_cmp_addr_d;
            r_fail_q      <= w_fail_d;
            r_fail_addr_q <= w_fail_addr_d;
            r_fail_cnt_q  <= w_fail_cnt_d;
        end
    end

    assign bist_fail = r_fail_q;
    assign fail_addr = r_fail_addr_q;
    assign fail_cnt  = r_fail_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mbist_march_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mbist_march_seq
// Function : Self-checking bench for mbist_march_seq with an address
//            generator model over 0..7 and a small SRAM with fault injection.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mbist_march_seq;

    localparam int             AW      = 9;
    localparam int             DW      = 32;
    localparam int             CW      = 4;
    // Background with bit0 = 0 so a stuck-at-1 on bit0 upsets the r0 reads
    localparam logic [DW-1:0]  c_PAT   = 32'hAAAA_AAAA;
    localparam logic [AW-1:0]  c_START = 9'd0;
    localparam logic [AW-1:0]  c_END   = 9'd7;
    localparam int             c_EDGES = 83;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bist_start = 1'b0;
    logic          last_addr;
    logic [AW-1:0] bist_addr = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          run, updown, scan_load, mem_cs, mem_we;
    logic [DW-1:0] mem_wdata;
    logic          bist_busy, bist_done, bist_fail;
    logic [AW-1:0] fail_addr;
    logic [CW-1:0] fail_cnt;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            fault_mode = 0;
    logic [DW-1:0] mem [0:7];

    mbist_march_seq #(
        .BIST_ADDR_WD (AW),
        .BIST_DATA_WD (DW),
        .BIST_DATA_PAT(c_PAT),
        .FAIL_CNT_WD  (CW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bist_start(bist_start),
        .last_addr (last_addr),
        .bist_addr (bist_addr),
        .mem_rdata (mem_rdata),
        .run       (run),
        .updown    (updown),
        .scan_load (scan_load),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .bist_busy (bist_busy),
        .bist_done (bist_done),
        .bist_fail (bist_fail),
        .fail_addr (fail_addr),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    // Address generator model: wraps end->start going up, start->end going down
    always @(posedge clk or posedge rst) begin
        if (rst)            bist_addr <= c_START;
        else if (scan_load) bist_addr <= c_START;
        else if (run) begin
            if (updown) bist_addr <= (bist_addr == c_END)   ? c_START : bist_addr + 9'd1;
            else        bist_addr <= (bist_addr == c_START) ? c_END   : bist_addr - 9'd1;
        end
    end
    assign last_addr = updown ? (bist_addr == c_END) : (bist_addr == c_START);

    function automatic logic [DW-1:0] fault_rd(input logic [DW-1:0] d, input logic [AW-1:0] a);
        logic [DW-1:0] r;
        r = d;
        if (fault_mode == 1 && a == 9'd5) r[0] = 1'b1;
        if (fault_mode == 2)              r = ~r;
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_cs && mem_we)  mem[bist_addr[2:0]] <= mem_wdata;
        if (mem_cs && !mem_we) mem_rdata <= fault_rd(mem[bist_addr[2:0]], bist_addr);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctl"}, {run, updown, scan_load, mem_cs, mem_we, bist_busy, bist_done, bist_fail},
              8'b0100_0000);
        check({name, "_wdata"}, mem_wdata, '0);
        check({name, "_faddr"}, fail_addr, '0);
        check({name, "_fcnt"},  fail_cnt,  '0);
    endtask

    // Pulse bist_start; n counts edges after the sampling edge until bist_done
    task automatic start_and_wait(output int n);
        @(negedge clk) bist_start = 1'b1;
        @(negedge clk) bist_start = 1'b0;
        n = 0;
        while (!bist_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Per-cycle record: {cs, we, run, updown, addr, wdata-if-write}
    logic [44:0] exp_q[$];

    task automatic build_trace();
        bit          wr_val [6] = '{0, 1, 0, 1, 0, 0};
        bit          rd_val [6] = '{0, 0, 1, 0, 1, 0};
        bit          up, wr, val;
        int          nops;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        exp_q.delete();
        for (int e = 0; e < 6; e++) begin
            up   = (e < 3);
            nops = (e == 0 || e == 5) ? 1 : 2;
            if (e == 3) exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, c_START, {DW{1'b0}}});
            for (int k = 0; k < 8; k++) begin
                a = up ? AW'(k) : AW'(7 - k);
                for (int op = 0; op < nops; op++) begin
                    wr  = (e == 0) || (op == 1);
                    val = wr ? wr_val[e] : rd_val[e];
                    wd  = wr ? (val ? ~c_PAT : c_PAT) : '0;
                    exp_q.push_back({1'b1, wr, (op == nops - 1) ? 1'b1 : 1'b0, up, a, wd});
                end
            end
        end
    endtask

    task automatic run_trace();
        logic [44:0] act;
        fault_mode = 0;
        build_trace();
        @(negedge clk) bist_start = 1'b1;
        @(negedge clk) bist_start = 1'b0;
        check("load_cycle", {scan_load, mem_cs, run, updown, bist_busy}, 5'b10011);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            act = {mem_cs, mem_we, run, updown, bist_addr, (mem_cs && mem_we) ? mem_wdata : {DW{1'b0}}};
            check($sformatf("trace[%0d]", i), act, exp_q[i]);
        end
        @(negedge clk);
        check("drain_cycle", {mem_cs, run, bist_busy, bist_done}, 4'b0010);
        @(negedge clk);
        check("trace_done", {bist_done, bist_busy, bist_fail}, 3'b100);
        check("trace_fcnt", fail_cnt, '0);
    endtask

    typedef struct {
        int            fmode;
        int            edges;
        logic          fail;
        logic [AW-1:0] faddr;
        logic [CW-1:0] fcnt;
    } vec_t;

    vec_t vecs[4];
    int   n;

    initial begin
        vecs[0] = '{fmode: 0, edges: c_EDGES, fail: 1'b0, faddr: 9'd0, fcnt: 4'd0};
        vecs[1] = '{fmode: 1, edges: c_EDGES, fail: 1'b1, faddr: 9'd5, fcnt: 4'd3};
        vecs[2] = '{fmode: 2, edges: c_EDGES, fail: 1'b1, faddr: 9'd0, fcnt: 4'd15};
        vecs[3] = '{fmode: 0, edges: c_EDGES, fail: 1'b0, faddr: 9'd0, fcnt: 4'd0};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");

        run_trace();

        foreach (vecs[i]) begin
            fault_mode = vecs[i].fmode;
            start_and_wait(n);
            check($sformatf("vec%0d_edges", i), n, vecs[i].edges);
            check($sformatf("vec%0d_busy", i),  bist_busy, 1'b0);
            check($sformatf("vec%0d_fail", i),  bist_fail, vecs[i].fail);
            check($sformatf("vec%0d_faddr", i), fail_addr, vecs[i].faddr);
            check($sformatf("vec%0d_fcnt", i),  fail_cnt,  vecs[i].fcnt);
        end

        // Start pulse while busy must not disturb completion timing
        fault_mode = 0;
        @(negedge clk) bist_start = 1'b1;
        @(negedge clk) bist_start = 1'b0;
        n = 0;
        repeat (30) begin @(negedge clk); n++; end
        bist_start = 1'b1;
        @(negedge clk);
        n++;
        bist_start = 1'b0;
        while (!bist_done && n < 2000) begin @(negedge clk); n++; end
        check("midstart_edges", n, c_EDGES);

        // Start from DONE with failing status: cleared and LOAD on the next cycle
        fault_mode = 2;
        start_and_wait(n);
        check("sat_again_fcnt", fail_cnt, 4'd15);
        fault_mode = 0;
        @(negedge clk) bist_start = 1'b1;
        @(negedge clk) bist_start = 1'b0;
        check("restart_load", {scan_load, bist_busy, bist_done, bist_fail}, 4'b1100);
        check("restart_fcnt", fail_cnt, '0);
        n = 0;
        while (!bist_done && n < 2000) begin @(negedge clk); n++; end
        check("restart_edges", n, c_EDGES);

        // Asynchronous reset in the middle of E3
        fault_mode = 1;
        @(negedge clk) bist_start = 1'b1;
        @(negedge clk) bist_start = 1'b0;
        repeat (45) @(negedge clk);
        check("e3_state", {bist_busy, updown, mem_cs, bist_fail}, 4'b1011);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_rst");
        fault_mode = 0;
        start_and_wait(n);
        check("after_rst_edges", n, c_EDGES);
        check("after_rst_status", {bist_fail, fail_cnt, fail_addr}, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mbist_march_seq.md
Name: mbist_march_seq

Overview:
- March C- sequencer sitting directly upstream of the MBIST address generator.
- Drives the generator's run/updown/scan_load and consumes its last_addr/bist_addr.
- Issues SRAM read/write ops with data background and checks read data.
- Reports done/fail status, first failing address and a saturating fail count.

Parameters:
- BIST_ADDR_WD, 9: address width; matches the address generator.
- BIST_DATA_WD, 32: memory data width.
- BIST_DATA_PAT, 32'h5555_5555: data background. "0" = PAT, "1" = ~PAT.
- FAIL_CNT_WD, 8: width of the fail counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- bist_start  in  1  start pulse; ignored unless state is IDLE or DONE
- last_addr  in  1  from address generator
- bist_addr  in  BIST_ADDR_WD  current address from address generator
- mem_rdata  in  BIST_DATA_WD  SRAM read data; valid the cycle after a read op
- run  out  1  advance address generator
- updown  out  1  1 = up, 0 = down
- scan_load  out  1  load generator address with its start address
- mem_cs  out  1  memory select
- mem_we  out  1  1 = write, 0 = read
- mem_wdata  out  BIST_DATA_WD  write data
- bist_busy  out  1  state not IDLE/DONE
- bist_done  out  1  high in DONE
- bist_fail  out  1  sticky: any mismatch this run
- fail_addr  out  BIST_ADDR_WD  address of first mismatch
- fail_cnt  out  FAIL_CNT_WD  mismatch count, saturating

Behaviour:
- Reset: state IDLE, elem=0, op=0. All outputs 0, except updown=1.
- March C- elements:
  - E0 up(w0)
  - E1 up(r0,w1)
  - E2 up(r1,w0)
  - E3 down(r0,w1)
  - E4 down(r1,w0)
  - E5 down(r0)
  - nops = 1 for E0 and E5; 2 otherwise.
- IDLE/DONE: on bist_start, clear bist_fail, fail_addr and fail_cnt; go to LOAD.
- LOAD (1 cycle): scan_load=1, run=0, updown=1, mem_cs=0. Next state RUN, elem=0, op=0.
- RUN:
  - mem_cs=1; mem_we and mem_wdata per the current op; updown = direction of elem.
  - run=1 only when op==nops-1. Otherwise op increments and the address holds.
  - op==nops-1 and last_addr=0: op<=0.
  - op==nops-1 and last_addr=1:
    - elem==5: go to DRAIN.
    - Otherwise elem++, op<=0.
    - If the new element's direction differs, go to TURN. This occurs only at E2->E3.
  - Address wrap (end->start on up, start->end on down) is done by the generator; the sequencer relies on it.
- TURN (1 cycle): mem_cs=0, run=1, updown = new direction. The generator moves start->end. Next state RUN.
- DRAIN (1 cycle): mem_cs=0, run=0; completes the last compare. Next state DONE.
- DONE: bist_done=1 and status held until bist_start or rst.
- Compare pipeline:
  - A read op registers exp = PAT or ~PAT, the address, and a cmp_vld flag.
  - In the next cycle, if cmp_vld and mem_rdata!=exp:
    - bist_fail<=1.
    - fail_cnt increments, saturating at all-ones.
    - fail_addr captured only when this is the first mismatch.
- Simultaneous events: bist_start while busy is ignored. The rst edge dominates everything.
- rst mid-run: immediate return to IDLE; status cleared, cmp_vld cleared. The address generator is reset separately.
- Timing, with N = end-start+1 addresses:
  - RUN+TURN last 10N+1 cycles.
  - bist_done first high after the clock edge 10N+3 edges after the edge that samples bist_start.

Test Plan:
- Clean run, range 0..7, fault-free memory model -> bist_done high 83 edges after start sample; bist_fail=0, fail_cnt=0. Write log: 8×w PAT ascending, then the E1/E2 patterns.
- Address trace -> E0-E2 ascend 0..7; one TURN cycle with mem_cs=0 moving the address 0->7; E3-E5 descend 7..0. run high only on the last op of each address.
- Stuck-at-1 bit 0 at address 5 -> E1 r0 mismatch at 5. fail_addr=5, bist_fail=1; fail_cnt=3 (E1, E3, E5 r0 reads).
- Every read forced wrong with FAIL_CNT_WD=4 -> fail_cnt saturates at 15; fail_addr=0 (first read in E1).
- rst asserted during E3, then restart -> all outputs at reset values immediately. A new bist_start completes normally with clean status.
- bist_start pulsed mid-run -> ignored, completion timing unchanged. bist_start in DONE -> status cleared, LOAD next cycle.
